slave_spi_mode: RTL and testbench

Parametrised SPI slave, successor to the fixed 8-bit mode-0 receiver.
- Configurable word width, all four CPOL/CPHA modes, and MSB- or LSB-first bit order.
- Full-duplex: transmit data is supplied through a ready/valid handshake; received words appear as a one-cycle valid pulse.
- Oversamples the external SPI pins in the system clock domain. Sits between the board pins and application logic such as the display driver.

---
 rtl/slave_spi_pkg.sv | 22 ++
 rtl/spi_pin_sync.sv | 45 ++++
 rtl/slave_spi_mode.sv | 217 +++++++++++++++++++++
 tb/tb_slave_spi_mode.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_spi_pkg.sv
// Shared definitions for the parametrised SPI slave.
// - MODE0..MODE3: SPI mode encodings as {CPOL, CPHA}.
// - state_e: frame state machine states.
// - cnt_width(): width of the per-word bit counter for a given word width.
package slave_spi_pkg;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_e;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, with registered
// edge pulses.
// Ports:
//   Clock   - system clock
//   Reset   - synchronous active-high reset; loads RESET_VAL into the chain
//   din_i   - asynchronous pin input
//   level_o - synchronised level (last synchroniser stage)
//   rise_o  - one-cycle pulse, registered, after a 0->1 of level_o
//   fall_o  - one-cycle pulse, registered, after a 1->0 of level_o
module spi_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic Clock,
  input  logic Reset,
  input  logic din_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      dly_q  <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      dly_q  <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[SYNC_STAGES-1] & dly_q;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/slave_spi_mode.sv
// Parametrised SPI slave: any CPOL/CPHA mode, WIDTH-bit words, MSB- or
// LSB-first, full duplex. Pins are oversampled in the Clock domain.
// Ports:
//   Clock, Reset          - system clock, synchronous active-high reset
//   CS_i, SCK_i, MOSI_i   - asynchronous SPI pins (CS active low)
//   MISO_o, MISO_OE_o     - slave data out and its enable (enable = frame active)
//   TxData_i/TxValid_i/TxReady_o - holding-register write handshake
//   RxData_o, RxValid_o   - last complete word and its one-cycle update pulse
//   Busy_o                - frame active
//   TxUnderrun_o          - pulse when a word starts with the holding register empty
module slave_spi_mode
  import slave_spi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CS_i,
  input  logic             SCK_i,
  input  logic             MOSI_i,
  output logic             MISO_o,
  output logic             MISO_OE_o,
  input  logic [WIDTH-1:0] TxData_i,
  input  logic             TxValid_i,
  output logic             TxReady_o,
  output logic [WIDTH-1:0] RxData_o,
  output logic             RxValid_o,
  output logic             Busy_o,
  output logic             TxUnderrun_o
);

  localparam int unsigned      CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [1:0]       MODE     = {CPOL, CPHA};
  // Modes 0 and 3 sample MOSI on the rising SCK edge; 1 and 2 on the falling one.
  localparam bit SAMPLE_ON_RISE = (MODE == MODE0) || (MODE == MODE3);

  // Bit that goes out first from a word.
  function automatic logic head(logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Drop the bit just sent.
  function automatic logic [WIDTH-1:0] advance(logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  // Shift a received bit into the RX register.
  function automatic logic [WIDTH-1:0] insert(logic [WIDTH-1:0] v, logic b);
    return MSB_FIRST ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
  endfunction

  logic cs_level_unused, cs_rise, cs_fall;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  // CS chain resets to the active level so a CS already low when reset is
  // released does not look like a fresh falling edge mid-frame.
  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_cs_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .din_i  (CS_i),
    .level_o(cs_level_unused),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (CPOL)
  ) u_sck_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .din_i  (SCK_i),
    .level_o(sck_level_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_mosi_sync (
    .Clock  (Clock),
    .Reset  (Reset),
    .din_i  (MOSI_i),
    .level_o(mosi_s),
    .rise_o (mosi_rise_unused),
    .fall_o (mosi_fall_unused)
  );

  state_e           state_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic [WIDTH-1:0] rx_shift_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q;
  logic [WIDTH-1:0] tx_shift_q;
  logic             miso_q;
  logic             reload_q;   // word finished; load a new TX word at next shift point
  logic             underrun_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;

  logic             sample_ev;
  logic             shift_ev;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] load_word;
  logic             cs_load;
  logic             reload;
  logic             move;

  assign sample_ev = SAMPLE_ON_RISE ? sck_rise : sck_fall;
  assign shift_ev  = SAMPLE_ON_RISE ? sck_fall : sck_rise;
  assign rx_next   = insert(rx_shift_q, mosi_s);
  assign load_word = hold_full_q ? hold_q : '0;

  assign cs_load = (state_q == IDLE) && cs_fall;
  assign reload  = (state_q == ACTIVE) && !cs_rise && shift_ev && reload_q;
  assign move    = cs_load || reload;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      reload_q    <= 1'b0;
      underrun_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_q    <= ACTIVE;
            bit_cnt_q  <= '0;
            reload_q   <= 1'b0;
            underrun_q <= !hold_full_q;
            if (CPHA) begin
              // First bit is presented on the first leading edge.
              tx_shift_q <= load_word;
              miso_q     <= 1'b0;
            end else begin
              tx_shift_q <= advance(load_word);
              miso_q     <= head(load_word);
            end
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Partial word is dropped; RX shift contents are simply overwritten later.
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            reload_q  <= 1'b0;
            miso_q    <= 1'b0;
          end else begin
            if (sample_ev) begin
              rx_shift_q <= rx_next;
              if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_q  <= '0;
                rx_data_q  <= rx_next;
                rx_valid_q <= 1'b1;
                reload_q   <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            if (shift_ev) begin
              if (reload_q) begin
                tx_shift_q <= advance(load_word);
                miso_q     <= head(load_word);
                underrun_q <= !hold_full_q;
                reload_q   <= 1'b0;
              end else begin
                tx_shift_q <= advance(tx_shift_q);
                miso_q     <= head(tx_shift_q);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      // A write in the same cycle as a move wins: the move took the old
      // contents, the new word stays held.
      if (move) begin
        hold_full_q <= 1'b0;
      end
      if (TxValid_i && !hold_full_q) begin
        hold_q      <= TxData_i;
        hold_full_q <= 1'b1;
      end
    end
  end

  assign MISO_o       = miso_q;
  assign MISO_OE_o    = (state_q == ACTIVE);
  assign Busy_o       = (state_q == ACTIVE);
  assign TxReady_o    = !hold_full_q;
  assign RxData_o     = rx_data_q;
  assign RxValid_o    = rx_valid_q;
  assign TxUnderrun_o = underrun_q;

endmodule

// File: tb/tb_slave_spi_mode.sv
// Bench for slave_spi_mode: five instances (modes 0..3 at 8 bits MSB-first,
// plus mode 0 at 16 bits LSB-first) driven by a bit-banged SPI master.
module tb_slave_spi_mode;

  localparam time HALF = 7894ns;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  cs;
  logic [4:0]  sck;
  logic        mosi;
  logic [31:0] tx_data [5];
  logic [4:0]  tx_valid;
  logic [4:0]  miso, oe, tx_ready, rx_valid, busy, under;
  logic [31:0] rx_data [5];

  int   checks = 0;
  int   errors = 0;
  int   rx_cnt  [5];
  int   und_cnt [5];
  exp_t sb [$];
  exp_t e;

  always #20ns clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int unsigned W  = (g == 4) ? 16 : 8;
    localparam bit          CP = (g == 2) || (g == 3);
    localparam bit          CH = (g == 1) || (g == 3);
    localparam bit          MF = (g != 4);
    logic [W-1:0] rxd;
    slave_spi_mode #(
      .WIDTH      (W),
      .CPOL       (CP),
      .CPHA       (CH),
      .MSB_FIRST  (MF),
      .SYNC_STAGES(2)
    ) u_dut (
      .Clock       (clk),
      .Reset       (rst),
      .CS_i        (cs[g]),
      .SCK_i       (sck[g]),
      .MOSI_i      (mosi),
      .MISO_o      (miso[g]),
      .MISO_OE_o   (oe[g]),
      .TxData_i    (tx_data[g][W-1:0]),
      .TxValid_i   (tx_valid[g]),
      .TxReady_o   (tx_ready[g]),
      .RxData_o    (rxd),
      .RxValid_o   (rx_valid[g]),
      .Busy_o      (busy[g]),
      .TxUnderrun_o(under[g])
    );
    assign rx_data[g] = 32'(rxd);
  end

  function automatic bit cpol_of(int g);
    return (g == 2) || (g == 3);
  endfunction
  function automatic bit cpha_of(int g);
    return (g == 1) || (g == 3);
  endfunction
  function automatic bit msb_of(int g);
    return g != 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input int g);
    chk("rst_miso", 32'(miso[g]), 32'h0);
    chk("rst_oe", 32'(oe[g]), 32'h0);
    chk("rst_txready", 32'(tx_ready[g]), 32'h1);
    chk("rst_rxdata", rx_data[g], 32'h0);
    chk("rst_rxvalid", 32'(rx_valid[g]), 32'h0);
    chk("rst_busy", 32'(busy[g]), 32'h0);
    chk("rst_underrun", 32'(under[g]), 32'h0);
  endtask

  task automatic cs_low(input int g);
    cs[g] = 1'b0;
    #HALF;
  endtask

  task automatic cs_high(input int g);
    #HALF;
    cs[g] = 1'b1;
    #HALF;
  endtask

  // Shift nbits of word through DUT g; cap gets what the master saw on MISO.
  task automatic xfer(input int g, input logic [31:0] word, input int nbits,
                      output logic [31:0] cap);
    int idx;
    bit cp;
    cp  = cpol_of(g);
    cap = '0;
    for (int k = 0; k < nbits; k++) begin
      idx = msb_of(g) ? nbits - 1 - k : k;
      if (!cpha_of(g)) begin
        mosi = word[idx];
        #HALF;
        sck[g]   = ~cp;
        cap[idx] = miso[g];
        #HALF;
        sck[g] = cp;
      end else begin
        #HALF;
        sck[g] = ~cp;
        mosi   = word[idx];
        #HALF;
        sck[g]   = cp;
        cap[idx] = miso[g];
      end
    end
  endtask

  task automatic load_tx(input int g, input logic [31:0] d);
    @(negedge clk);
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    @(negedge clk);
    tx_valid[g] = 1'b0;
  endtask

  // Scoreboard consumer and pulse counters.
  always @(negedge clk) begin
    for (int g = 0; g < 5; g++) begin
      if (under[g]) und_cnt[g]++;
      if (rx_valid[g]) begin
        rx_cnt[g]++;
        if (sb.size() > 0) e = sb.pop_front();
        else e = '{idx: 99, data: 32'h0};
        chk("rx_dut", 32'(g), 32'(e.idx));
        chk("rx_data", rx_data[g], e.data);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] cap;
    logic [31:0] w1 [4];
    int c0;
    int u0;

    w1[0] = 32'h01; w1[1] = 32'h03; w1[2] = 32'h07; w1[3] = 32'h0F;
    for (int g = 0; g < 5; g++) begin
      tx_data[g] = '0;
      rx_cnt[g]  = 0;
      und_cnt[g] = 0;
    end
    rst      = 1'b1;
    cs       = '1;
    sck      = 5'b01100;
    mosi     = 1'b0;
    tx_valid = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    for (int g = 0; g < 5; g++) chk_reset(g);

    // 1: four words back to back in one frame, mode 0.
    for (int i = 0; i < 4; i++) sb.push_back('{idx: 0, data: w1[i]});
    cs_low(0);
    for (int i = 0; i < 4; i++) begin
      xfer(0, w1[i], 8, cap);
      chk("t1_busy", 32'(busy[0]), 32'h1);
      chk("t1_miso_underrun", cap, 32'h0);
    end
    cs_high(0);
    chk("t1_rxcnt", 32'(rx_cnt[0]), 32'd4);

    // 2: TX word A5, then an underrun word.
    load_tx(0, 32'hA5);
    chk("t2_ready_low", 32'(tx_ready[0]), 32'h0);
    sb.push_back('{idx: 0, data: 32'h5A});
    cs_low(0);
    chk("t2_ready_high", 32'(tx_ready[0]), 32'h1);
    chk("t2_oe", 32'(oe[0]), 32'h1);
    chk("t2_first_bit", 32'(miso[0]), 32'h1);
    xfer(0, 32'h5A, 8, cap);
    chk("t2_miso_a5", cap, 32'hA5);
    u0 = und_cnt[0];
    repeat (10) @(negedge clk);
    chk("t2_underrun", 32'(und_cnt[0] - u0), 32'h1);
    chk("t2_miso_zero", 32'(miso[0]), 32'h0);
    sb.push_back('{idx: 0, data: 32'h66});
    xfer(0, 32'h66, 8, cap);
    chk("t2_miso_word2", cap, 32'h0);
    cs_high(0);
    chk("t2_oe_off", 32'(oe[0]), 32'h0);

    // 3: modes 1..3, master 3C / slave C3.
    for (int g = 1; g < 4; g++) begin
      load_tx(g, 32'hC3);
      sb.push_back('{idx: g, data: 32'h3C});
      cs_low(g);
      xfer(g, 32'h3C, 8, cap);
      cs_high(g);
      chk("t3_miso", cap, 32'hC3);
      chk("t3_rxcnt", 32'(rx_cnt[g]), 32'h1);
    end

    // 4: 16-bit LSB-first word, no pulse at the half-way point.
    sb.push_back('{idx: 4, data: 32'h1234});
    c0 = rx_cnt[4];
    cs_low(4);
    xfer(4, 32'h34, 8, cap);
    repeat (20) @(negedge clk);
    chk("t4_no_half", 32'(rx_cnt[4] - c0), 32'h0);
    xfer(4, 32'h12, 8, cap);
    repeat (20) @(negedge clk);
    chk("t4_full", 32'(rx_cnt[4] - c0), 32'h1);
    cs_high(4);

    // 5: aborted 5-bit frame, then a full 81.
    c0 = rx_cnt[0];
    cs_low(0);
    xfer(0, 32'h16, 5, cap);
    cs_high(0);
    chk("t5_oe_gap", 32'(oe[0]), 32'h0);
    chk("t5_busy_gap", 32'(busy[0]), 32'h0);
    chk("t5_no_partial", 32'(rx_cnt[0] - c0), 32'h0);
    sb.push_back('{idx: 0, data: 32'h81});
    cs_low(0);
    xfer(0, 32'h81, 8, cap);
    cs_high(0);
    chk("t5_cnt", 32'(rx_cnt[0] - c0), 32'h1);

    // 6: reset after 3 bits, then a clean AA frame.
    c0 = rx_cnt[0];
    cs_low(0);
    xfer(0, 32'h5, 3, cap);
    load_tx(0, 32'h5A);
    chk("t6_ready_pre", 32'(tx_ready[0]), 32'h0);
    chk("t6_busy_pre", 32'(busy[0]), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset(0);
    repeat (10) @(negedge clk);
    chk("t6_idle_after", 32'(busy[0]), 32'h0);
    cs[0] = 1'b1;
    #HALF;
    sb.push_back('{idx: 0, data: 32'hAA});
    cs_low(0);
    xfer(0, 32'hAA, 8, cap);
    cs_high(0);
    chk("t6_cnt", 32'(rx_cnt[0] - c0), 32'h1);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
